uart_core_cfg: RTL and testbench
================================

// Module: uart_core_cfg
// PURPOSE
// Parametrised full-duplex UART: baud tick generator, TX/RX serialisers, one TX and one RX FIFO.
// Next generation of the fixed 8N1 UART top. Adds:
// - configurable data width and FIFO depth
// - runtime baud divisor, parity and stop-bit count
// - RX glitch rejection, and parity/framing/overrun error reporting
// Sits between the host register interface and the board pins.
// PARAMETERS
// DBITS       8   data bits per frame, legal 5..8
// FIFO_DEPTH  16  entries per FIFO, power of 2, >=2
// OVS         16  baud ticks per bit, even, >=4
// DIV_W       16  width of divisor port
// PORTS
// clk           in   1          system clock, only clock
// rstn          in   1          asynchronous active-low reset
// divisor       in   DIV_W      clk cycles per baud tick; 0 behaves as 1
// parity_en     in   1          1 = parity bit after data
// parity_odd    in   1          1 = odd parity, 0 = even
// stop2         in   1          1 = two TX stop bits
// wr_en         in   1          push wdata into TX FIFO; ignored when tx_full
// wdata         in   DBITS      TX byte
// rd_en         in   1          pop RX FIFO head; ignored when rx_empty
// rdata         out  DBITS      RX FIFO head (first-word-fall-through), valid while !rx_empty
// rx            in   1          serial input, asynchronous
// tx            out  1          serial output, idle high
// tx_full       out  1          TX FIFO full
// rx_empty      out  1          RX FIFO empty
// tx_busy       out  1          TX FSM not IDLE, or TX FIFO not empty
// err_clr       in   1          clears all sticky error flags
// rx_frame_err  out  1          sticky: stop bit sampled 0
// rx_par_err    out  1          sticky: parity mismatch
// rx_overrun    out  1          sticky: good frame arrived while RX FIFO full
// BEHAVIOUR
// Reset values: tx=1, tx_full=0, rx_empty=1, tx_busy=0, rdata=0, all error flags 0.
// Reset: FIFOs empty, FSMs IDLE, tick counter 0. rstn low mid-frame aborts the frame immediately.
// Baud tick:
// - one-cycle pulse when cnt==max(divisor,1)-1; cnt then wraps to 0
// - a divisor change takes effect at the next wrap
// TX FSM: IDLE->START->DATA->[PARITY]->STOP->IDLE. Each bit lasts OVS ticks; data sent LSB first.
// - IDLE with FIFO non-empty: pop the head and latch it together with parity_en/parity_odd/stop2.
// - The frame uses only these latched values; config changes mid-frame apply to the next frame.
// - STOP lasts OVS or 2*OVS ticks. Back-to-back frames leave no idle gap.
// RX:
// - rx passes through a 2-FF synchroniser; latency counts from the synchronised value
// - IDLE->START on synchronised rx==0
// - START: after OVS/2 ticks re-sample; if 1, glitch, return to IDLE with no flag
// - DATA, PARITY and STOP are then sampled every OVS ticks (mid-bit)
// - parity_en/parity_odd are latched at START; RX checks one stop bit only
// RX frame end (one cycle after the stop sample):
// - stop==0: set rx_frame_err, discard the frame
// - else parity mismatch: set rx_par_err, discard the frame
// - else RX FIFO full: set rx_overrun, drop the frame
// - else push the frame
// rx held low (break) after a framing error: stay IDLE until rx has been 1 for a full tick.
// FIFOs:
// - push on a full FIFO is ignored; pop on an empty FIFO is ignored
// - simultaneous push+pop when full: both occur, count unchanged
// - simultaneous push+pop when empty: push only
// - pointers are log2(DEPTH)+1 bits wide; full/empty come from the MSB compare and wrap cleanly
// - rdata updates the cycle after a pop, or the cycle after the first push into an empty FIFO
// Errors: err_clr wins over a same-cycle set. Flags stay set until err_clr.
// STRUCTURE
// Package uart_pkg: frame-state enum (IDLE, START, DATA, PARITY, STOP), legal-range localparams for DBITS/OVS.
// Sub-module uart_sync_fifo #(W, DEPTH), instantiated twice.
// Tick generator, TX FSM and RX FSM stay inline.
// TESTING
// 1. divisor=1, DBITS=8, no parity; write 0xA5 -> tx shows 0, then 1,0,1,0,0,1,0,1, then 1; each bit lasts 16 clk; tx_busy drops after stop.
// 2. Loop tx->rx, parity_en=1, parity_odd=1, stop2=1; write 0x00,0xFF,0x3C -> same three bytes read in order; no error flags.
// 3. Drive a 0x55 frame with stop bit 0 -> rx_frame_err=1, rx_empty stays 1; err_clr -> flag returns to 0.
// 4. Depth 16: write 17 bytes with tx stalled (divisor max) -> tx_full after 16 writes; 17th write dropped; 16 bytes transmitted.
// 5. Receive 17 frames without reading -> 16 stored, rx_overrun=1; reads return the first 16 in order.
// 6. rx low pulse of OVS/4 ticks -> no frame, no flags. Also: rstn low mid-TX-frame -> tx=1 on the same cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared frame-state type and parameter limits for the UART core
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam int DBITS_MIN = 5;
    localparam int DBITS_MAX = 8;
    localparam int OVS_MIN   = 4;
    localparam int IDX_W     = $clog2(DBITS_MAX);

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through synchronous FIFO with wrap-bit pointers
module uart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    // A pop frees the slot being written, so a full FIFO still accepts a concurrent push.
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= wdata;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_core_cfg.sv
// rtl/uart_core_cfg.sv - parametrised full-duplex UART with runtime baud, parity and stop config
module uart_core_cfg
    import uart_pkg::*;
#(
    parameter int DBITS      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVS        = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] divisor,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             stop2,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wdata,
    input  logic             rd_en,
    output logic [DBITS-1:0] rdata,
    input  logic             rx,
    output logic             tx,
    output logic             tx_full,
    output logic             rx_empty,
    output logic             tx_busy,
    input  logic             err_clr,
    output logic             rx_frame_err,
    output logic             rx_par_err,
    output logic             rx_overrun
);

    localparam int TCW = $clog2(2*OVS);
    localparam int RCW = $clog2(OVS);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_baud_cnt;
    logic [DIV_W-1:0] w_div_eff;
    logic             w_tick;

    assign w_div_eff = (divisor == '0) ? DIV_W'(1) : divisor;
    assign w_tick    = (r_baud_cnt == r_div - DIV_W'(1));

    // Divisor is captured only at the wrap so a change never truncates a tick in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_baud_cnt <= '0;
            r_div      <= DIV_W'(1);
        end else if (w_tick) begin
            r_baud_cnt <= '0;
            r_div      <= w_div_eff;
        end else begin
            r_baud_cnt <= r_baud_cnt + DIV_W'(1);
        end
    end

    frame_state_t     r_tx_state;
    logic [TCW-1:0]   r_tx_cnt;
    logic [IDX_W-1:0] r_tx_idx;
    logic [DBITS-1:0] r_tx_shift;
    logic             r_tx_par_en;
    logic             r_tx_stop2;
    logic             r_tx_par;
    logic             r_tx;
    logic [TCW-1:0]   w_tx_last;
    logic             w_tx_bit_end;
    logic             w_txf_pop;
    logic             w_txf_empty;
    logic [DBITS-1:0] w_txf_rdata;

    assign w_tx_last    = (r_tx_state == STOP && r_tx_stop2) ? TCW'(2*OVS-1) : TCW'(OVS-1);
    assign w_tx_bit_end = w_tick && (r_tx_cnt == w_tx_last);
    assign w_txf_pop    = w_tick && !w_txf_empty &&
                          ((r_tx_state == IDLE) || (r_tx_state == STOP && w_tx_bit_end));
    assign tx           = r_tx;
    assign tx_busy      = (r_tx_state != IDLE) || !w_txf_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_state  <= IDLE;
            r_tx_cnt    <= '0;
            r_tx_idx    <= '0;
            r_tx_shift  <= '0;
            r_tx_par_en <= 1'b0;
            r_tx_stop2  <= 1'b0;
            r_tx_par    <= 1'b0;
            r_tx        <= 1'b1;
        end else if (w_txf_pop) begin
            r_tx_state  <= START;
            r_tx_cnt    <= '0;
            r_tx_shift  <= w_txf_rdata;
            r_tx_par    <= (^w_txf_rdata) ^ parity_odd;
            r_tx_par_en <= parity_en;
            r_tx_stop2  <= stop2;
            r_tx        <= 1'b0;
        end else if (r_tx_state != IDLE && w_tick) begin
            if (!w_tx_bit_end) begin
                r_tx_cnt <= r_tx_cnt + TCW'(1);
            end else begin
                r_tx_cnt <= '0;
                case (r_tx_state)
                    START: begin
                        r_tx_state <= DATA;
                        r_tx_idx   <= '0;
                        r_tx       <= r_tx_shift[0];
                    end
                    DATA: begin
                        if (r_tx_idx == IDX_W'(DBITS-1)) begin
                            r_tx_state <= r_tx_par_en ? PARITY : STOP;
                            r_tx       <= r_tx_par_en ? r_tx_par : 1'b1;
                        end else begin
                            r_tx_idx   <= r_tx_idx + IDX_W'(1);
                            r_tx       <= r_tx_shift[1];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end
                    PARITY: begin
                        r_tx_state <= STOP;
                        r_tx       <= 1'b1;
                    end
                    default: begin
                        r_tx_state <= IDLE;
                        r_tx       <= 1'b1;
                    end
                endcase
            end
        end
    end

    frame_state_t     r_rx_state;
    logic             r_rx_s1;
    logic             r_rx_s2;
    logic [RCW-1:0]   r_rx_cnt;
    logic [IDX_W-1:0] r_rx_idx;
    logic [DBITS-1:0] r_rx_shift;
    logic             r_rx_par_en;
    logic             r_rx_par_odd;
    logic             r_rx_par_bit;
    logic             r_rx_stop_bit;
    logic             r_rx_done;
    logic             r_rx_brk;
    logic             r_rx_brk_hi;
    logic             w_rx_sample;

    assign w_rx_sample = w_tick &&
        (r_rx_cnt == ((r_rx_state == START) ? RCW'(OVS/2-1) : RCW'(OVS-1)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_s1       <= 1'b1;
            r_rx_s2       <= 1'b1;
            r_rx_state    <= IDLE;
            r_rx_cnt      <= '0;
            r_rx_idx      <= '0;
            r_rx_shift    <= '0;
            r_rx_par_en   <= 1'b0;
            r_rx_par_odd  <= 1'b0;
            r_rx_par_bit  <= 1'b0;
            r_rx_stop_bit <= 1'b1;
            r_rx_done     <= 1'b0;
            r_rx_brk      <= 1'b0;
            r_rx_brk_hi   <= 1'b0;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_done <= 1'b0;
            case (r_rx_state)
                IDLE: begin
                    // After a framing error the line must sit high across a whole tick before re-arming.
                    if (r_rx_brk) begin
                        if (!r_rx_s2) begin
                            r_rx_brk_hi <= 1'b0;
                        end else if (w_tick) begin
                            if (r_rx_brk_hi) r_rx_brk <= 1'b0;
                            r_rx_brk_hi <= 1'b1;
                        end
                    end else if (!r_rx_s2) begin
                        r_rx_state   <= START;
                        r_rx_cnt     <= '0;
                        r_rx_par_en  <= parity_en;
                        r_rx_par_odd <= parity_odd;
                    end
                end
                default: begin
                    if (w_tick && !w_rx_sample) begin
                        r_rx_cnt <= r_rx_cnt + RCW'(1);
                    end else if (w_rx_sample) begin
                        r_rx_cnt <= '0;
                        case (r_rx_state)
                            START: begin
                                r_rx_state <= r_rx_s2 ? IDLE : DATA;
                                r_rx_idx   <= '0;
                            end
                            DATA: begin
                                r_rx_shift <= {r_rx_s2, r_rx_shift[DBITS-1:1]};
                                if (r_rx_idx == IDX_W'(DBITS-1)) begin
                                    r_rx_state <= r_rx_par_en ? PARITY : STOP;
                                end else begin
                                    r_rx_idx <= r_rx_idx + IDX_W'(1);
                                end
                            end
                            PARITY: begin
                                r_rx_par_bit <= r_rx_s2;
                                r_rx_state   <= STOP;
                            end
                            default: begin
                                r_rx_stop_bit <= r_rx_s2;
                                r_rx_done     <= 1'b1;
                                r_rx_state    <= IDLE;
                                r_rx_brk      <= !r_rx_s2;
                                r_rx_brk_hi   <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    logic w_par_bad;
    logic w_rxf_full;
    logic w_rxf_push;
    logic w_frame_ok;

    assign w_par_bad  = r_rx_par_en && (r_rx_par_bit != ((^r_rx_shift) ^ r_rx_par_odd));
    assign w_frame_ok = r_rx_done && r_rx_stop_bit && !w_par_bad;
    assign w_rxf_push = w_frame_ok && !w_rxf_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_frame_err <= 1'b0;
            rx_par_err   <= 1'b0;
            rx_overrun   <= 1'b0;
        end else if (err_clr) begin
            rx_frame_err <= 1'b0;
            rx_par_err   <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            if (r_rx_done && !r_rx_stop_bit)               rx_frame_err <= 1'b1;
            if (r_rx_done && r_rx_stop_bit && w_par_bad)   rx_par_err   <= 1'b1;
            if (w_frame_ok && w_rxf_full)                  rx_overrun   <= 1'b1;
        end
    end

    uart_sync_fifo #(.W(DBITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (wr_en),
        .pop   (w_txf_pop),
        .wdata (wdata),
        .rdata (w_txf_rdata),
        .full  (tx_full),
        .empty (w_txf_empty)
    );

    uart_sync_fifo #(.W(DBITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_rxf_push),
        .pop   (rd_en),
        .wdata (r_rx_shift),
        .rdata (rdata),
        .full  (w_rxf_full),
        .empty (rx_empty)
    );

endmodule

// File: tb/tb_uart_core_cfg.sv
// tb/tb_uart_core_cfg.sv - directed table-driven bench for uart_core_cfg
module tb_uart_core_cfg;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] divisor = 16'd1;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        stop2 = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        rd_en = 1'b0;
    logic [7:0]  rdata;
    logic        loop_en = 1'b0;
    logic        rx_drv = 1'b1;
    logic        rx_w;
    logic        tx;
    logic        tx_full;
    logic        rx_empty;
    logic        tx_busy;
    logic        err_clr = 1'b0;
    logic        rx_frame_err;
    logic        rx_par_err;
    logic        rx_overrun;

    int checks = 0;
    int errors = 0;

    assign rx_w = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_core_cfg #(.DBITS(8), .FIFO_DEPTH(16), .OVS(16), .DIV_W(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .divisor      (divisor),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .stop2        (stop2),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rx           (rx_w),
        .tx           (tx),
        .tx_full      (tx_full),
        .rx_empty     (rx_empty),
        .tx_busy      (tx_busy),
        .err_clr      (err_clr),
        .rx_frame_err (rx_frame_err),
        .rx_par_err   (rx_par_err),
        .rx_overrun   (rx_overrun)
    );

    typedef struct {
        int   offset;
        logic exp_tx;
        logic exp_busy;
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_odd;
        logic       stop2;
    } lb_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_odd;
        logic       par_bit;
        logic       stop_bit;
        logic       exp_fe;
        logic       exp_pe;
        logic       exp_push;
    } rx_vec_t;

    tx_vec_t tx_tab[21];
    lb_vec_t lb_tab[4];
    rx_vec_t rx_tab[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wdata = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic check_flags(input string name, input logic fe, input logic pe, input logic ov);
        check({name, "_frame_err"}, rx_frame_err, fe);
        check({name, "_par_err"}, rx_par_err, pe);
        check({name, "_overrun"}, rx_overrun, ov);
    endtask

    task automatic read_expect(input string name, input logic [7:0] exp, input int budget);
        int n = 0;
        while (rx_empty && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_avail"}, rx_empty, 1'b0);
        check({name, "_rdata"}, rdata, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wait_tx_idle(input string name, input int budget);
        int n = 0;
        while (tx_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_tx_idle"}, tx_busy, 1'b0);
    endtask

    task automatic wait_tx_low(input string name);
        int n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_tx_start"}, tx, 1'b0);
    endtask

    // 16 clk per bit because the bench runs with divisor 1 and OVS 16.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic sbit);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (16) @(negedge clk);
        end
        if (pen) begin
            rx_drv = pbit;
            repeat (16) @(negedge clk);
        end
        rx_drv = sbit;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [9:0] exp_seq;
        logic [7:0] ov_data;
        int cur;

        exp_seq = 10'b1_1010_0101_0;
        for (int i = 0; i < 10; i++) begin
            tx_tab[2*i]   = '{offset: 16*i,      exp_tx: exp_seq[i], exp_busy: 1'b1};
            tx_tab[2*i+1] = '{offset: 16*i + 15, exp_tx: exp_seq[i], exp_busy: 1'b1};
        end
        tx_tab[20] = '{offset: 160, exp_tx: 1'b1, exp_busy: 1'b0};

        lb_tab[0] = '{data: 8'hA5, par_en: 1'b0, par_odd: 1'b0, stop2: 1'b0};
        lb_tab[1] = '{data: 8'h5A, par_en: 1'b1, par_odd: 1'b0, stop2: 1'b0};
        lb_tab[2] = '{data: 8'h01, par_en: 1'b1, par_odd: 1'b1, stop2: 1'b0};
        lb_tab[3] = '{data: 8'hC3, par_en: 1'b0, par_odd: 1'b0, stop2: 1'b1};

        rx_tab[0] = '{data: 8'h55, par_en: 1'b0, par_odd: 1'b0, par_bit: 1'b0, stop_bit: 1'b0,
                      exp_fe: 1'b1, exp_pe: 1'b0, exp_push: 1'b0};
        rx_tab[1] = '{data: 8'h55, par_en: 1'b1, par_odd: 1'b1, par_bit: 1'b0, stop_bit: 1'b1,
                      exp_fe: 1'b0, exp_pe: 1'b1, exp_push: 1'b0};
        rx_tab[2] = '{data: 8'h96, par_en: 1'b1, par_odd: 1'b0, par_bit: 1'b0, stop_bit: 1'b1,
                      exp_fe: 1'b0, exp_pe: 1'b0, exp_push: 1'b1};
        rx_tab[3] = '{data: 8'h07, par_en: 1'b1, par_odd: 1'b1, par_bit: 1'b0, stop_bit: 1'b1,
                      exp_fe: 1'b0, exp_pe: 1'b0, exp_push: 1'b1};
        rx_tab[4] = '{data: 8'h07, par_en: 1'b1, par_odd: 1'b0, par_bit: 1'b0, stop_bit: 1'b1,
                      exp_fe: 1'b0, exp_pe: 1'b1, exp_push: 1'b0};
        rx_tab[5] = '{data: 8'h80, par_en: 1'b1, par_odd: 1'b0, par_bit: 1'b0, stop_bit: 1'b0,
                      exp_fe: 1'b1, exp_pe: 1'b0, exp_push: 1'b0};

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_tx_full", tx_full, 1'b0);
        check("rst_rx_empty", rx_empty, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Single 0xA5 frame, 8N1, each bit checked at its first and last clock.
        write_byte(8'hA5);
        wait_tx_low("t1");
        cur = 0;
        for (int k = 0; k < 21; k++) begin
            while (cur < tx_tab[k].offset) begin
                @(negedge clk);
                cur++;
            end
            check($sformatf("t1_tx_off%0d", cur), tx, tx_tab[k].exp_tx);
            check($sformatf("t1_busy_off%0d", cur), tx_busy, tx_tab[k].exp_busy);
        end

        // Loopback, three back-to-back frames with odd parity and two stop bits.
        loop_en = 1'b1;
        parity_en = 1'b1;
        parity_odd = 1'b1;
        stop2 = 1'b1;
        write_byte(8'h00);
        write_byte(8'hFF);
        write_byte(8'h3C);
        wait_tx_idle("t2", 2000);
        repeat (40) @(negedge clk);
        read_expect("t2_b0", 8'h00, 10);
        read_expect("t2_b1", 8'hFF, 10);
        read_expect("t2_b2", 8'h3C, 10);
        check("t2_empty", rx_empty, 1'b1);
        check_flags("t2", 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            parity_en = lb_tab[k].par_en;
            parity_odd = lb_tab[k].par_odd;
            stop2 = lb_tab[k].stop2;
            write_byte(lb_tab[k].data);
            wait_tx_idle($sformatf("lb%0d", k), 1000);
            repeat (40) @(negedge clk);
            read_expect($sformatf("lb%0d", k), lb_tab[k].data, 10);
            check_flags($sformatf("lb%0d", k), 1'b0, 1'b0, 1'b0);
        end
        loop_en = 1'b0;
        stop2 = 1'b0;

        // Directly driven frames: framing and parity errors, and good frames.
        for (int k = 0; k < 6; k++) begin
            parity_en = rx_tab[k].par_en;
            parity_odd = rx_tab[k].par_odd;
            send_frame(rx_tab[k].data, rx_tab[k].par_en, rx_tab[k].par_bit, rx_tab[k].stop_bit);
            repeat (40) @(negedge clk);
            check_flags($sformatf("rx%0d", k), rx_tab[k].exp_fe, rx_tab[k].exp_pe, 1'b0);
            check($sformatf("rx%0d_empty", k), rx_empty, !rx_tab[k].exp_push);
            if (rx_tab[k].exp_push) read_expect($sformatf("rx%0d", k), rx_tab[k].data, 10);
            pulse_err_clr();
            check_flags($sformatf("rx%0d_clr", k), 1'b0, 1'b0, 1'b0);
        end
        parity_en = 1'b0;

        // Break after a bad stop bit must not start a phantom frame.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        rx_drv = 1'b0;
        repeat (60) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("brk_empty", rx_empty, 1'b1);
        check("brk_fe", rx_frame_err, 1'b1);
        pulse_err_clr();
        send_frame(8'h3A, 1'b0, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        read_expect("brk_next", 8'h3A, 10);
        check_flags("brk_next", 1'b0, 1'b0, 1'b0);

        // Glitch of OVS/4 ticks.
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_empty", rx_empty, 1'b1);
        check_flags("glitch", 1'b0, 1'b0, 1'b0);

        // 17 frames into a 16-deep RX FIFO.
        for (int i = 0; i < 17; i++) begin
            ov_data = 8'(i * 29 + 3);
            send_frame(ov_data, 1'b0, 1'b0, 1'b1);
            if (i == 15) begin
                repeat (4) @(negedge clk);
                check("ov_not_yet", rx_overrun, 1'b0);
            end
        end
        repeat (20) @(negedge clk);
        check_flags("ov", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            ov_data = 8'(i * 29 + 3);
            read_expect($sformatf("ov_rd%0d", i), ov_data, 10);
        end
        check("ov_drained", rx_empty, 1'b1);
        pulse_err_clr();

        // Reset in the middle of a TX start bit must force tx high immediately.
        write_byte(8'h33);
        wait_tx_low("rst_mid");
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy", tx_busy, 1'b0);
        check("rst_mid_rdata", rdata, 8'h00);
        divisor = 16'hFFFF;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // TX FIFO fill while the baud tick is stalled at the maximum divisor.
        loop_en = 1'b1;
        for (int i = 0; i < 15; i++) write_byte(8'(8'h40 + i));
        check("fill15_full", tx_full, 1'b0);
        check("fill15_busy", tx_busy, 1'b1);
        write_byte(8'h4F);
        check("fill16_full", tx_full, 1'b1);
        write_byte(8'hEE);
        check("fill17_full", tx_full, 1'b1);
        divisor = 16'd1;
        for (int i = 0; i < 16; i++) begin
            read_expect($sformatf("fill_rd%0d", i), 8'(8'h40 + i), (i == 0) ? 70000 : 400);
        end
        wait_tx_idle("fill", 500);
        repeat (40) @(negedge clk);
        check("fill_no17", rx_empty, 1'b1);
        check_flags("fill", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
